ahb_mtx_l1_in_stg: RTL and testbench

Input stage of the L1 AHB bus matrix. One instance sits between each master (slave-side AHB port) and the output-stage arbiters. When the targeted output stage has not granted this port, the block registers the master's address phase, stalls the master with wait states, and keeps requesting until the output stage accepts the held transfer. It generates the per-port request that the output-stage arbiters consume, and the address/control the matrix decoder steers.

---
 rtl/ahb_mtx_l1_in_stg.sv | 121 ++++++++++++
 tb/tb_ahb_mtx_l1_in_stg.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mtx_l1_in_stg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_mtx_l1_in_stg
// Brief    : L1 AHB matrix input stage; holds an ungranted address phase and
//            stalls the master until the output stage accepts it.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_mtx_l1_in_stg #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    input  logic                  active_trans,
    input  logic                  dec_readyout,
    input  logic                  dec_resp,
    output logic                  HREADYOUTS,
    output logic                  HRESPS,
    output logic                  trans_req,
    output logic [1:0]            HTRANSM,
    output logic [ADDR_WIDTH-1:0] HADDRM,
    output logic                  HWRITEM,
    output logic [2:0]            HSIZEM,
    output logic [2:0]            HBURSTM,
    output logic [3:0]            HPROTM,
    output logic                  HMASTLOCKM,
    output logic                  trans_pend
);

    typedef enum logic [0:0] {
        ST_PASS = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    w_live_valid;
    logic                    w_capture;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              trans_q;
    logic                    write_q;
    logic [2:0]              size_q;
    logic [2:0]              burst_q;
    logic [3:0]              prot_q;
    logic                    mastlock_q;

    // Only NONSEQ/SEQ accepted by the master-side bus can start a transfer.
    assign w_live_valid = HSELS & HTRANSS[1] & HREADYS;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_PASS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        w_capture = 1'b0;
        case (state_q)
            ST_PASS: begin
                if (w_live_valid && !active_trans) begin
                    state_d   = ST_HOLD;
                    w_capture = 1'b1;
                end
            end
            ST_HOLD: begin
                if (active_trans) begin
                    state_d = ST_PASS;
                end
            end
            default: state_d = ST_PASS;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q     <= '0;
            trans_q    <= 2'b00;
            write_q    <= 1'b0;
            size_q     <= 3'b000;
            burst_q    <= 3'b000;
            prot_q     <= 4'b0000;
            mastlock_q <= 1'b0;
        end else if (w_capture) begin
            addr_q     <= HADDRS;
            trans_q    <= HTRANSS;
            write_q    <= HWRITES;
            size_q     <= HSIZES;
            burst_q    <= HBURSTS;
            prot_q     <= HPROTS;
            mastlock_q <= HMASTLOCKS;
        end
    end

    assign trans_pend = (state_q == ST_HOLD);
    assign trans_req  = trans_pend | w_live_valid;

    assign HTRANSM    = trans_pend ? trans_q    : (HSELS ? HTRANSS : 2'b00);
    assign HADDRM     = trans_pend ? addr_q     : HADDRS;
    assign HWRITEM    = trans_pend ? write_q    : HWRITES;
    assign HSIZEM     = trans_pend ? size_q     : HSIZES;
    assign HBURSTM    = trans_pend ? burst_q    : HBURSTS;
    assign HPROTM     = trans_pend ? prot_q     : HPROTS;
    assign HMASTLOCKM = trans_pend ? mastlock_q : HMASTLOCKS;

    // Capture only happens with HREADYS=1, so no data phase is masked here.
    assign HREADYOUTS = trans_pend ? 1'b0 : dec_readyout;
    assign HRESPS     = trans_pend ? 1'b0 : dec_resp;

endmodule
`default_nettype wire

// File: tb/tb_ahb_mtx_l1_in_stg.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_mtx_l1_in_stg
// Brief    : Directed self-checking bench for the L1 matrix input stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_mtx_l1_in_stg;

    localparam int ADDR_WIDTH = 32;

    logic                  HCLK;
    logic                  HRESETn;
    logic                  HSELS;
    logic [ADDR_WIDTH-1:0] HADDRS;
    logic [1:0]            HTRANSS;
    logic                  HWRITES;
    logic [2:0]            HSIZES;
    logic [2:0]            HBURSTS;
    logic [3:0]            HPROTS;
    logic                  HMASTLOCKS;
    logic                  HREADYS;
    logic                  active_trans;
    logic                  dec_readyout;
    logic                  dec_resp;
    logic                  HREADYOUTS;
    logic                  HRESPS;
    logic                  trans_req;
    logic [1:0]            HTRANSM;
    logic [ADDR_WIDTH-1:0] HADDRM;
    logic                  HWRITEM;
    logic [2:0]            HSIZEM;
    logic [2:0]            HBURSTM;
    logic [3:0]            HPROTM;
    logic                  HMASTLOCKM;
    logic                  trans_pend;

    int r_checks = 0;
    int r_errors = 0;

    ahb_mtx_l1_in_stg #(.ADDR_WIDTH(ADDR_WIDTH)) u_dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .HSELS        (HSELS),
        .HADDRS       (HADDRS),
        .HTRANSS      (HTRANSS),
        .HWRITES      (HWRITES),
        .HSIZES       (HSIZES),
        .HBURSTS      (HBURSTS),
        .HPROTS       (HPROTS),
        .HMASTLOCKS   (HMASTLOCKS),
        .HREADYS      (HREADYS),
        .active_trans (active_trans),
        .dec_readyout (dec_readyout),
        .dec_resp     (dec_resp),
        .HREADYOUTS   (HREADYOUTS),
        .HRESPS       (HRESPS),
        .trans_req    (trans_req),
        .HTRANSM      (HTRANSM),
        .HADDRM       (HADDRM),
        .HWRITEM      (HWRITEM),
        .HSIZEM       (HSIZEM),
        .HBURSTM      (HBURSTM),
        .HPROTM       (HPROTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .trans_pend   (trans_pend)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                         input logic wr, input logic act);
        HSELS        = sel;
        HTRANSS      = trans;
        HADDRS       = addr;
        HWRITES      = wr;
        active_trans = act;
    endtask

    initial begin
        HRESETn      = 1'b0;
        HSELS        = 1'b0;
        HADDRS       = '0;
        HTRANSS      = 2'b00;
        HWRITES      = 1'b0;
        HSIZES       = 3'd0;
        HBURSTS      = 3'd0;
        HPROTS       = 4'd0;
        HMASTLOCKS   = 1'b0;
        HREADYS      = 1'b1;
        active_trans = 1'b0;
        dec_readyout = 1'b1;
        dec_resp     = 1'b0;

        // Reset state
        #12;
        chk("rst_pend",   32'(trans_pend), 32'd0);
        chk("rst_req",    32'(trans_req),  32'd0);
        chk("rst_htrans", 32'(HTRANSM),    32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick();
        #1;
        chk("rel_ready", 32'(HREADYOUTS), 32'd1);
        chk("rel_resp",  32'(HRESPS),     32'd0);

        // Immediate grant: forwarded combinationally, never held
        drive(1'b1, 2'b10, 32'h2000_0010, 1'b1, 1'b1);
        #1;
        chk("ig_addr",  HADDRM,            32'h2000_0010);
        chk("ig_trans", 32'(HTRANSM),      32'd2);
        chk("ig_write", 32'(HWRITEM),      32'd1);
        chk("ig_req",   32'(trans_req),    32'd1);
        tick();
        drive(1'b1, 2'b00, 32'h0, 1'b0, 1'b0);
        dec_readyout = 1'b0;
        #1;
        chk("ig_pend",    32'(trans_pend), 32'd0);
        chk("ig_rdy_lo",  32'(HREADYOUTS), 32'd0);
        dec_readyout = 1'b1;
        #1;
        chk("ig_rdy_hi",  32'(HREADYOUTS), 32'd1);

        // Contention: issue cycle not granted, then three more waiting cycles
        tick();
        drive(1'b1, 2'b10, 32'h2000_0040, 1'b0, 1'b0);
        HSIZES     = 3'd2;
        HBURSTS    = 3'd1;
        HPROTS     = 4'hA;
        HMASTLOCKS = 1'b1;
        #1;
        chk("ct_req_issue", 32'(trans_req), 32'd1);
        tick();
        // Master keeps changing the bus while stalled; the hold must ignore it
        drive(1'b1, 2'b11, 32'hDEAD_0000, 1'b1, 1'b0);
        HSIZES     = 3'd0;
        HBURSTS    = 3'd0;
        HPROTS     = 4'h0;
        HMASTLOCKS = 1'b0;
        dec_resp   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ct_pend",  32'(trans_pend), 32'd1);
            chk("ct_addr",  HADDRM,          32'h2000_0040);
            chk("ct_ready", 32'(HREADYOUTS), 32'd0);
            chk("ct_req",   32'(trans_req),  32'd1);
            tick();
        end
        active_trans = 1'b1;
        #1;
        chk("ct_g_ready", 32'(HREADYOUTS), 32'd0);
        chk("ct_g_resp",  32'(HRESPS),     32'd0);
        chk("ct_g_trans", 32'(HTRANSM),    32'd2);
        chk("ct_g_write", 32'(HWRITEM),    32'd0);
        chk("ct_g_size",  32'(HSIZEM),     32'd2);
        chk("ct_g_burst", 32'(HBURSTM),    32'd1);
        chk("ct_g_prot",  32'(HPROTM),     32'hA);
        chk("ct_g_lock",  32'(HMASTLOCKM), 32'd1);
        tick();
        drive(1'b1, 2'b00, 32'h0, 1'b0, 1'b0);
        dec_resp = 1'b0;
        #1;
        chk("ct_released", 32'(trans_pend), 32'd0);
        chk("ct_rdy_back", 32'(HREADYOUTS), 32'd1);

        // Filtering: IDLE, BUSY, unselected NONSEQ
        for (int i = 0; i < 3; i++) begin
            tick();
            case (i)
                0:       drive(1'b1, 2'b00, 32'h3000_0000, 1'b0, 1'b0);
                1:       drive(1'b1, 2'b01, 32'h3000_0004, 1'b0, 1'b0);
                default: drive(1'b0, 2'b10, 32'h3000_0008, 1'b0, 1'b0);
            endcase
            #1;
            chk("flt_req", 32'(trans_req), 32'd0);
            if (i == 2) chk("flt_htrans_unsel", 32'(HTRANSM), 32'd0);
            tick();
            chk("flt_pend", 32'(trans_pend), 32'd0);
        end

        // HREADYS low (first cycle of a two-cycle ERROR): no capture
        drive(1'b1, 2'b10, 32'h4000_0000, 1'b0, 1'b0);
        HREADYS = 1'b0;
        #1;
        chk("hrdy_req", 32'(trans_req), 32'd0);
        tick();
        drive(1'b1, 2'b00, 32'h0, 1'b0, 1'b0);
        HREADYS = 1'b1;
        #1;
        chk("hrdy_pend", 32'(trans_pend), 32'd0);

        // Reset mid-hold drops the transfer
        tick();
        drive(1'b1, 2'b10, 32'h5000_0000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
        #1;
        chk("rh_pend1", 32'(trans_pend), 32'd1);
        tick();
        #2;
        HRESETn = 1'b0;
        #1;
        chk("rh_pend_async", 32'(trans_pend), 32'd0);
        chk("rh_ready",      32'(HREADYOUTS), 32'd1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick();
        tick();
        chk("rh_no_reissue_pend", 32'(trans_pend), 32'd0);
        chk("rh_no_reissue_req",  32'(trans_req),  32'd0);
        chk("rh_addr_zero",       HADDRM,          32'h0);

        $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
        $finish;
    end

endmodule
`default_nettype wire
